// File: rtl/tt_req_scheduler.sv
// tt_req_scheduler: round-robin arbiter sharing the FSM datapath among
// N_REQ requesters, with bounded grant hold time and an inter-grant guard gap.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ena      1 = run, 0 = freeze state, counters and outputs
//   req      level request per requester
//   done     release strobe, only done[owner] is honoured
//   grant    one-hot grant (registered)
//   owner    index of current / last grantee (registered)
//   busy     1 while a grant is held (registered)
//   timeout  1-cycle pulse on forced release at MAX_HOLD (registered)
//   state    debug state: 00 IDLE, 01 GRANT, 10 GUARD
//
// Optional feature: define SCHED_PREEMPT_EN to make requester 0 high
// priority (it preempts any other owner and wins the next arbitration).
module tt_req_scheduler #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     timeout,
    output logic [1:0]               state
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = 4;

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [OW-1:0] PTR_RST   = OW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GRANT = 2'b01,
        S_GUARD = 2'b10
    } state_e;

    state_e          state_q;
    logic [N_REQ-1:0] grant_q;
    logic [OW-1:0]   owner_q;
    logic            busy_q;
    logic            timeout_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [GW-1:0]   gap_cnt_q;
    logic [OW-1:0]   rr_ptr_q;

    // Round-robin search: the lowest offset k (1..N_REQ) from rr_ptr
    // with a set request wins. Scanning offsets downward lets the last
    // hit (smallest offset) overwrite the earlier ones.
    logic            pick_vld;
    logic [OW-1:0]   pick_idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(rr_ptr_q) + k) % N_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = OW'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end

    // Final selection, possibly overridden by a pending preemption.
    logic            sel_vld_d;
    logic [OW-1:0]   sel_idx_d;
    logic            preempt;

`ifdef SCHED_PREEMPT_EN
    logic            pend_q;

    assign preempt = req[0] & (owner_q != '0);

    always_comb begin
        sel_vld_d = pick_vld;
        sel_idx_d = pick_idx;
        if (pend_q && req[0]) begin
            sel_vld_d = 1'b1;
            sel_idx_d = '0;
        end
    end
`else
    assign preempt   = 1'b0;
    assign sel_vld_d = pick_vld;
    assign sel_idx_d = pick_idx;
`endif

    // Owner-driven release has priority over preemption and timeout.
    logic own_rel;
    logic hold_end;

    assign own_rel  = done[owner_q] | ~req[owner_q];
    assign hold_end = (hold_cnt_q == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rr_ptr_q   <= PTR_RST;
`ifdef SCHED_PREEMPT_EN
            pend_q     <= 1'b0;
`endif
        end else if (ena) begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_vld_d) begin
                        state_q    <= S_GRANT;
                        grant_q    <= N_REQ'(1) << sel_idx_d;
                        owner_q    <= sel_idx_d;
                        rr_ptr_q   <= sel_idx_d;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= '0;
`ifdef SCHED_PREEMPT_EN
                        pend_q     <= 1'b0;
`endif
                    end
                end
                S_GRANT: begin
                    if (own_rel || preempt || hold_end) begin
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        gap_cnt_q <= '0;
                        timeout_q <= hold_end & ~own_rel & ~preempt;
                        state_q   <= (GAP > 0) ? S_GUARD : S_IDLE;
`ifdef SCHED_PREEMPT_EN
                        pend_q    <= preempt & ~own_rel;
`endif
                    end else begin
                        // Never reaches past HOLD_LAST, so no wrap.
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                S_GUARD: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding 2'b11: recover to IDLE.
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule
